// File: rtl/cpu_isa_pkg.sv
// ISA constants and fetch-stage types shared by the fetch unit and its next-PC logic.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b010100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int unsigned OpcodeMsb  = 31;
  localparam int unsigned OpcodeLsb  = 26;
  localparam int unsigned JTargetMsb = 25;
  localparam int unsigned JTargetLsb = 0;

  typedef enum logic {
    StRun,
    StFault
  } fetch_state_e;

  // How the fetch registers update this cycle.
  typedef enum logic [1:0] {
    SelLoad,
    SelHold,
    SelSquash,
    SelFault
  } fetch_sel_e;

  // A fetch address is usable only if word aligned and inside the instruction memory.
  function automatic logic pc_illegal(logic [31:0] pc, int unsigned imem_words);
    return (pc[1:0] != 2'b00) || (pc >= imem_words * 4);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect, fault, stall, local jump decode, sequential.
module fetch_next_pc
  import cpu_isa_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        redirect_fault_i,
  input  logic        stall_i,
  input  logic        pc_fault_i,
  input  logic        in_fault_i,
  output logic [31:0] pc4_o,
  output logic [31:0] next_pc_o,
  output fetch_sel_e  sel_o
);

  logic        is_jump;
  logic [31:0] jump_tgt;

  assign pc4_o    = pc_i + 32'd4;
  assign is_jump  = (instr_i[OpcodeMsb:OpcodeLsb] == OP_J);
  assign jump_tgt = {pc4_o[31:28], instr_i[JTargetMsb:JTargetLsb], 2'b00};

  always_comb begin
    next_pc_o = pc_i;
    sel_o     = SelHold;
    if (in_fault_i) begin
      // Stall is ignored while faulted; only a redirect moves the PC.
      sel_o = SelFault;
      if (redirect_valid_i) begin
        next_pc_o = redirect_pc_i;
        sel_o     = redirect_fault_i ? SelFault : SelSquash;
      end
    end else if (redirect_valid_i) begin
      next_pc_o = redirect_pc_i;
      sel_o     = SelSquash;
    end else if (pc_fault_i) begin
      sel_o = SelFault;
    end else if (stall_i) begin
      sel_o = SelHold;
    end else begin
      next_pc_o = is_jump ? jump_tgt : pc4_o;
      sel_o     = SelLoad;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register and the sticky fetch fault.
module fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_WORDS = 200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;

  logic [31:0] pc4;
  logic [31:0] next_pc;
  fetch_sel_e  sel;
  logic        pc_fault;
  logic        redirect_fault;

  assign pc_fault       = pc_illegal(pc_q, IMEM_WORDS);
  assign redirect_fault = pc_illegal(redirect_pc, IMEM_WORDS);

  fetch_next_pc u_next_pc (
    .pc_i             (pc_q),
    .instr_i          (imem_instr),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .redirect_fault_i (redirect_fault),
    .stall_i          (stall),
    .pc_fault_i       (pc_fault),
    .in_fault_i       (state_q == StFault),
    .pc4_o            (pc4),
    .next_pc_o        (next_pc),
    .sel_o            (sel)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (sel)
      SelLoad: begin
        pc_d    = next_pc;
        instr_d = imem_instr;
        pc4_d   = pc4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
      SelHold: ;
      SelSquash: begin
        pc_d    = next_pc;
        valid_d = 1'b0;
        state_d = StRun;
      end
      SelFault: begin
        // Faulting word is never loaded; the PC only moves on a redirect.
        pc_d    = next_pc;
        valid_d = 1'b0;
        state_d = StFault;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fault       = (state_q == StFault);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test-plan scenarios followed by randomized traffic against a behavioural fetch model.
module tb_fetch_unit;

  localparam int unsigned Words = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [Words];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_fault;

  fetch_unit #(
    .RESET_PC   (32'd0),
    .IMEM_WORDS (Words)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_instr = 32'hFFFF_FFFF;
    if (imem_addr < Words * 4) imem_instr = mem[imem_addr / 4];
  end

  function automatic bit illegal(logic [31:0] a);
    return (a % 4 != 0) || (a >= Words * 4);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of the architectural fetch behaviour, stated directly from the rules.
  task automatic model_step(input bit r, input bit s, input bit rv, input logic [31:0] rp);
    logic [31:0] w, nxt;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
    end else if (m_fault) begin
      if (rv) begin
        m_pc    = rp;
        m_valid = 0;
        m_fault = illegal(rp);
      end
    end else if (rv) begin
      m_pc    = rp;
      m_valid = 0;
    end else if (illegal(m_pc)) begin
      m_fault = 1;
      m_valid = 0;
    end else if (!s) begin
      w   = mem[m_pc / 4];
      nxt = m_pc + 4;
      m_instr = w;
      m_pc4   = nxt;
      m_valid = 1;
      m_count = m_count + 1;
      if (w[31:26] == 6'b000010) m_pc = {nxt[31:28], w[25:0], 2'b00};
      else m_pc = nxt;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit rv, input logic [31:0] rp);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    model_step(r, s, rv, rp);
    @(posedge clk);
    @(negedge clk);
    check_eq("m_addr", imem_addr, m_pc);
    check_eq("m_instr", if_id_instr, m_instr);
    check_eq("m_pc4", if_id_pc4, m_pc4);
    check_eq("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check_eq("m_fault", {31'd0, fault}, {31'd0, m_fault});
    check_eq("m_count", fetch_count, m_count);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] rp;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    for (int i = 0; i < Words; i++) mem[i] = 32'd0;
    mem[20] = 32'h0800_0010;
    @(negedge clk);

    // Reset and sequential fetch over nops
    cycle(1, 0, 0, 0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 0);
      check_eq("seq_addr", imem_addr, 32'(4 * i));
      check_eq("seq_pc4", if_id_pc4, 32'(4 * i));
      check_eq("seq_valid", {31'd0, if_id_valid}, 32'd1);
    end
    check_eq("seq_count", fetch_count, 32'd3);

    // Jump at word 20 to byte 64
    repeat (17) cycle(0, 0, 0, 0);
    check_eq("pre_jump_addr", imem_addr, 32'd80);
    cycle(0, 0, 0, 0);
    check_eq("jump_addr", imem_addr, 32'd64);
    check_eq("jump_instr", if_id_instr, 32'h0800_0010);
    check_eq("jump_pc4", if_id_pc4, 32'd84);
    check_eq("jump_valid", {31'd0, if_id_valid}, 32'd1);
    cycle(0, 0, 0, 0);
    check_eq("post_jump_addr", imem_addr, 32'd68);

    // Redirect overriding a stall
    cycle(0, 1, 1, 32'h1F4);
    check_eq("redir_addr", imem_addr, 32'h1F4);
    check_eq("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("redir_count", fetch_count, 32'd22);

    // Stall hold at pc 24
    cycle(0, 0, 1, 32'd24);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      check_eq("stall_addr", imem_addr, 32'd24);
      check_eq("stall_pc4", if_id_pc4, 32'd68);
      check_eq("stall_valid", {31'd0, if_id_valid}, 32'd0);
    end
    cycle(0, 0, 0, 0);
    check_eq("release_addr", imem_addr, 32'd28);
    check_eq("release_pc4", if_id_pc4, 32'd28);

    // Out-of-range redirect, then recovery
    cycle(0, 0, 1, 32'd800);
    check_eq("oor_addr", imem_addr, 32'd800);
    cycle(0, 0, 0, 0);
    check_eq("oor_fault", {31'd0, fault}, 32'd1);
    check_eq("oor_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 1, 0, 0);
    check_eq("oor_hold", imem_addr, 32'd800);
    cycle(0, 0, 1, 32'd8);
    check_eq("recover_fault", {31'd0, fault}, 32'd0);
    check_eq("recover_addr", imem_addr, 32'd8);
    cycle(0, 0, 0, 0);
    check_eq("recover_next", imem_addr, 32'd12);
    check_eq("recover_pc4", if_id_pc4, 32'd12);

    // Misaligned fault, illegal redirect while faulted, reset mid-fault
    cycle(0, 0, 1, 32'h6);
    cycle(0, 0, 0, 0);
    check_eq("mis_fault", {31'd0, fault}, 32'd1);
    cycle(0, 1, 1, 32'd900);
    check_eq("refault_addr", imem_addr, 32'd900);
    check_eq("refault_fault", {31'd0, fault}, 32'd1);
    cycle(1, 0, 0, 0);
    check_eq("rst2_fault", {31'd0, fault}, 32'd0);
    check_eq("rst2_addr", imem_addr, 32'd0);
    check_eq("rst2_count", fetch_count, 32'd0);

    // Randomized traffic with jumps, stalls, redirects and occasional reset
    for (int i = 0; i < Words; i++) begin
      w = $urandom;
      if ($urandom_range(7) == 0) w = {6'b000010, 26'($urandom_range(Words - 1))};
      else if ($urandom_range(5) == 0) w = 32'd0;
      mem[i] = w;
    end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rp = 32'($urandom_range(Words - 1)) * 4;
      if ($urandom_range(6) == 0) rp = $urandom_range(1023);
      cycle($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0, rp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
